// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a word store,
// with a registered 128-bit round-key read port.
module aes_key_expand_seq #(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned RK_IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [0:255]        cipher_key,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  output logic                err,
  output logic [3:0]          nr,
  input  logic                rk_rd_en,
  input  logic [RK_IDX_W-1:0] rk_idx,
  output logic [0:127]        rk_data,
  output logic                rk_vld
);

  localparam int unsigned MaxNr    = (MAX_KEY_BITS >= 256) ? 14 :
                                     (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int unsigned MaxWords = 4 * (MaxNr + 1);
  localparam int unsigned AddrW    = 6;

  // S-box, entry b at bits [2047-8b -: 8].
  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTab[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic [AddrW-1:0] i_q, i_d;
  logic [2:0]       p_q, p_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             key_valid_q, key_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [0:127]     rk_data_q;
  logic             rk_vld_q;
  logic [31:0]      w_q [MaxWords];

  logic             len_ok, accept, reject;
  logic [3:0]       nk_new, nr_new;
  logic [31:0]      prev_w, old_w, sub_in, sub_out, temp_w, new_w;
  logic             rd_ok;
  logic [AddrW-1:0] rd_base;

  always_comb begin
    len_ok = 1'b0;
    nk_new = 4'd4;
    nr_new = 4'd10;
    unique case (key_len)
      2'd0: begin len_ok = (MAX_KEY_BITS >= 128); nk_new = 4'd4; nr_new = 4'd10; end
      2'd1: begin len_ok = (MAX_KEY_BITS >= 192); nk_new = 4'd6; nr_new = 4'd12; end
      2'd2: begin len_ok = (MAX_KEY_BITS >= 256); nk_new = 4'd8; nr_new = 4'd14; end
      default: len_ok = 1'b0;
    endcase
    accept = start && (state_q != StExpand) && len_ok;
    reject = start && (state_q != StExpand) && !len_ok;
  end

  // Word datapath: one shared 4-byte S-box serves both the p==0 and the Nk==8/p==4 cases.
  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    old_w   = w_q[i_q - {2'b00, nk_q}];
    sub_in  = (p_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    if (p_q == 3'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && p_q == 3'd4) begin
      temp_w = sub_out;
    end else begin
      temp_w = prev_w;
    end
    new_w = old_w ^ temp_w;
  end

  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    i_d         = i_q;
    p_d         = p_q;
    rcon_d      = rcon_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    err_d       = reject;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          nk_d        = nk_new;
          nr_d        = nr_new;
          i_d         = {2'b00, nk_new};
          p_d         = 3'd0;
          rcon_d      = 8'h01;
          key_valid_d = 1'b0;
          state_d     = StExpand;
        end
      end
      StExpand: begin
        i_d = i_q + 6'd1;
        p_d = ({1'b0, p_q} == nk_q - 4'd1) ? 3'd0 : p_q + 3'd1;
        if (p_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        // Last word index W-1 = 4*Nr+3.
        if (i_q == {nr_q, 2'b11}) begin
          state_d     = StDone;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      nk_q        <= 4'd0;
      nr_q        <= 4'd0;
      i_q         <= '0;
      p_q         <= 3'd0;
      rcon_q      <= 8'h00;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      nr_q        <= nr_d;
      i_q         <= i_d;
      p_q         <= p_d;
      rcon_q      <= rcon_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < MaxWords; j++) begin
        w_q[j] <= '0;
      end
    end else if (accept) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_new)) begin
          w_q[j] <= cipher_key[32*j +: 32];
        end
      end
    end else if (state_q == StExpand) begin
      w_q[i_q] <= new_w;
    end
  end

  // A read coinciding with an accepted start sees key_valid already cleared.
  always_comb begin
    rd_ok   = key_valid_q && !accept && (int'(rk_idx) <= int'(nr_q));
    rd_base = AddrW'(rk_idx) << 2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_data_q <= '0;
      rk_vld_q  <= 1'b0;
    end else begin
      rk_vld_q <= rk_rd_en;
      if (rk_rd_en) begin
        rk_data_q <= rd_ok ? {w_q[rd_base], w_q[rd_base + 6'd1],
                              w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} : '0;
      end
    end
  end

  assign ready     = (state_q != StExpand);
  assign busy      = (state_q == StExpand);
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign nr        = nr_q;
  assign rk_data   = rk_data_q;
  assign rk_vld    = rk_vld_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 key-expansion vectors.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [0:255] cipher_key;
  logic         ready, busy, done, key_valid, err;
  logic [3:0]   nr;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic         rk_vld;

  // Second instance limited to AES-128.
  logic         s_start;
  logic [1:0]   s_key_len;
  logic         s_ready, s_busy, s_done, s_key_valid, s_err;
  logic [3:0]   s_nr;
  logic         s_rk_rd_en;
  logic [3:0]   s_rk_idx;
  logic [0:127] s_rk_data;
  logic         s_rk_vld;

  int checks = 0;
  int errors = 0;

  localparam logic [0:255] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'hdeadbeef0123456789abcdefcafef00d};
  localparam logic [0:255] Key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hffffffffffffffff};
  localparam logic [0:255] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .cipher_key(cipher_key),
    .ready(ready), .busy(busy), .done(done), .key_valid(key_valid), .err(err), .nr(nr),
    .rk_rd_en(rk_rd_en), .rk_idx(rk_idx), .rk_data(rk_data), .rk_vld(rk_vld)
  );

  aes_key_expand_seq #(.MAX_KEY_BITS(128), .RK_IDX_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .key_len(s_key_len), .cipher_key(Key256),
    .ready(s_ready), .busy(s_busy), .done(s_done), .key_valid(s_key_valid), .err(s_err),
    .nr(s_nr), .rk_rd_en(s_rk_rd_en), .rk_idx(s_rk_idx), .rk_data(s_rk_data),
    .rk_vld(s_rk_vld)
  );

  task automatic do_start(input logic [1:0] len, input logic [0:255] key);
    @(negedge clk);
    start = 1'b1; key_len = len; cipher_key = key;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin cyc = n; break; end
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [0:127] data, output logic vld);
    @(negedge clk);
    rk_rd_en = 1'b1; rk_idx = idx;
    @(posedge clk);
    @(negedge clk);
    data = rk_data; vld = rk_vld;
    rk_rd_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [0:127] d; logic v;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (nr !== 4'd0) begin errors++; $display("FAIL reset_nr: got %0d want 0", nr); end
    checks++; if (rk_vld !== 1'b0) begin errors++; $display("FAIL reset_rk_vld: got %b want 0", rk_vld); end
    checks++; if (rk_data !== 128'h0) begin errors++; $display("FAIL reset_rk_data: got %h want 0", rk_data); end
    read_rk(4'd0, d, v);
    checks++; if (v !== 1'b1 || d !== 128'h0) begin errors++; $display("FAIL reset_read: got vld=%b data=%h want vld=1 data=0", v, d); end
    @(negedge clk);
    checks++; if (rk_vld !== 1'b0) begin errors++; $display("FAIL idle_rk_vld: got %b want 0", rk_vld); end
  endtask

  task automatic test_err;
    @(negedge clk);
    start = 1'b1; key_len = 2'd3; cipher_key = Key128;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_reserved: got %b want 1", err); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_ready: got ready=%b busy=%b want 1/0", ready, busy); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL err_key_valid: got %b want 0", key_valid); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", err); end
    s_start = 1'b1; s_key_len = 2'd2;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    checks++; if (s_err !== 1'b1 || s_busy !== 1'b0) begin errors++; $display("FAIL err_too_long: got err=%b busy=%b want 1/0", s_err, s_busy); end
    s_start = 1'b1; s_key_len = 2'd0;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    checks++; if (s_err !== 1'b0 || s_busy !== 1'b1) begin errors++; $display("FAIL small_accept128: got err=%b busy=%b want 0/1", s_err, s_busy); end
  endtask

  task automatic test_aes128;
    int cyc; logic [0:127] d; logic v;
    do_start(2'd0, Key128);
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL a128_busy: got busy=%b ready=%b want 1/0", busy, ready); end
    wait_done(cyc);
    checks++; if (cyc !== 40) begin errors++; $display("FAIL a128_latency: got %0d want 40", cyc); end
    checks++; if (key_valid !== 1'b1 || ready !== 1'b1 || nr !== 4'd10) begin errors++; $display("FAIL a128_status: got kv=%b ready=%b nr=%0d want 1/1/10", key_valid, ready, nr); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL a128_done_pulse: got %b want 0", done); end
    read_rk(4'd0, d, v);
    checks++; if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL a128_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", d); end
    read_rk(4'd1, d, v);
    checks++; if (d !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1) begin errors++; $display("FAIL a128_rk1: got %h vld=%b want a0fafe1788542cb123a339392a6c7605", d, v); end
    read_rk(4'd10, d, v);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL a128_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
    read_rk(4'd11, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b1) begin errors++; $display("FAIL a128_rk11_oob: got %h vld=%b want 0 vld=1", d, v); end
  endtask

  task automatic test_aes192;
    int cyc; logic [0:127] d; logic v;
    do_start(2'd1, Key192);
    wait_done(cyc);
    checks++; if (cyc !== 46) begin errors++; $display("FAIL a192_latency: got %0d want 46", cyc); end
    checks++; if (nr !== 4'd12) begin errors++; $display("FAIL a192_nr: got %0d want 12", nr); end
    read_rk(4'd12, d, v);
    checks++; if (d !== 128'he98ba06f448c773c8ecc720401002202) begin errors++; $display("FAIL a192_rk12: got %h want e98ba06f448c773c8ecc720401002202", d); end
  endtask

  task automatic test_aes256;
    int cyc; logic [0:127] d; logic v;
    do_start(2'd2, Key256);
    wait_done(cyc);
    checks++; if (cyc !== 52) begin errors++; $display("FAIL a256_latency: got %0d want 52", cyc); end
    checks++; if (nr !== 4'd14) begin errors++; $display("FAIL a256_nr: got %0d want 14", nr); end
    read_rk(4'd1, d, v);
    checks++; if (d !== 128'h1f352c073b6108d72d9810a30914dff4) begin errors++; $display("FAIL a256_rk1: got %h want 1f352c073b6108d72d9810a30914dff4", d); end
    read_rk(4'd14, d, v);
    checks++; if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL a256_rk14: got %h want fe4890d1e6188d0b046df344706c631e", d); end
    do_start(2'd3, Key128);
    checks++; if (err !== 1'b1 || key_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_reject: got err=%b kv=%b busy=%b want 1/1/0", err, key_valid, busy); end
    read_rk(4'd14, d, v);
    checks++; if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL done_reject_keep: got %h want fe4890d1e6188d0b046df344706c631e", d); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [0:127] d; logic v;
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; cipher_key = Key128;
    rk_rd_en = 1'b1; rk_idx = 4'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rk_rd_en = 1'b0;
    checks++; if (key_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_kv_drop: got kv=%b busy=%b want 0/1", key_valid, busy); end
    checks++; if (rk_vld !== 1'b1 || rk_data !== 128'h0) begin errors++; $display("FAIL b2b_same_edge_read: got vld=%b data=%h want 1/0", rk_vld, rk_data); end
    wait_done(cyc);
    checks++; if (cyc !== 40 || nr !== 4'd10) begin errors++; $display("FAIL b2b_latency: got %0d nr=%0d want 40 nr=10", cyc, nr); end
    read_rk(4'd12, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b1) begin errors++; $display("FAIL b2b_rk12: got %h vld=%b want 0 vld=1", d, v); end
    read_rk(4'd0, d, v);
    checks++; if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL b2b_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", d); end
  endtask

  task automatic test_start_mid;
    int cyc; int err_seen; logic [0:127] d; logic v;
    do_start(2'd0, Key128);
    cyc = -1; err_seen = 0;
    for (int n = 1; n <= 200; n++) begin
      if (n == 10) begin start = 1'b1; key_len = 2'd2; cipher_key = Key256; end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (err) err_seen++;
      if (done) begin cyc = n; break; end
    end
    checks++; if (cyc !== 40) begin errors++; $display("FAIL mid_start_latency: got %0d want 40", cyc); end
    checks++; if (err_seen !== 0 || nr !== 4'd10) begin errors++; $display("FAIL mid_start_ignored: got err_count=%0d nr=%0d want 0/10", err_seen, nr); end
    read_rk(4'd10, d, v);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL mid_start_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
  endtask

  task automatic test_rst_mid;
    int done_seen;
    do_start(2'd0, Key128);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got ready=%b busy=%b done=%b err=%b want 1/0/0/0", ready, busy, done, err); end
    checks++; if (key_valid !== 1'b0 || nr !== 4'd0 || rk_vld !== 1'b0 || rk_data !== 128'h0) begin errors++; $display("FAIL rst_mid_out: got kv=%b nr=%0d vld=%b data=%h want all zero", key_valid, nr, rk_vld, rk_data); end
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", done_seen); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; cipher_key = '0;
    rk_rd_en = 1'b0; rk_idx = 4'd0;
    s_start = 1'b0; s_key_len = 2'd0; s_rk_rd_en = 1'b0; s_rk_idx = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_err();
    test_aes128();
    test_aes192();
    test_aes256();
    test_back_to_back();
    test_start_mid();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
